mips_mc_controller: RTL and testbench

Multi-cycle control unit for the MIPS core, successor to the single-cycle `controller`. It sequences each instruction through fetch, decode, execute, memory and write-back states, and stalls on a memory ready handshake. It drives the same datapath control buses as the single-cycle design, plus state-qualified write enables, a bus-timeout error and a retired-instruction counter. It sits beside `datapath` under `mips`.

---
 rtl/mips_pkg.sv | 83 ++++++++
 rtl/mips_mc_decode.sv | 84 ++++++++
 rtl/mips_mc_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_mips_mc_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS encodings, state and select definitions
// Purpose: opcode/funct constants, controller state enum, instruction
//          class codes and the mux-select encodings shared by the
//          controller, its decoder and the datapath muxes.
// Ports:   none (package).
package mips_pkg;

    // Opcode field (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Funct field (IR[5:0]) for R-type
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // PCSrc
    localparam logic [1:0] PCSRC_PC4 = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_JMP = 2'd2;
    localparam logic [1:0] PCSRC_REG = 2'd3;

    // Regdst
    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    // MemtoReg
    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC4 = 2'd2;

    // ALUOp
    localparam logic [2:0] ALUOP_ADD = 3'd0;
    localparam logic [2:0] ALUOP_SUB = 3'd1;
    localparam logic [2:0] ALUOP_OR  = 3'd2;
    localparam logic [2:0] ALUOP_LUI = 3'd3;

    // Sign (immediate extension)
    localparam logic [1:0] SIGN_ZERO  = 2'd0;
    localparam logic [1:0] SIGN_SEXT  = 2'd1;
    localparam logic [1:0] SIGN_UPPER = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH,
        S_FWAIT,
        S_DECODE,
        S_EXE,
        S_MEM,
        S_MWAIT,
        S_WB,
        S_JUMP,
        S_ERR
    } state_t;

    // Instruction class: what path the FSM takes after DECODE.
    // C_ALU covers addu/subu/ori/lui (EXE then WB).
    typedef enum logic [2:0] {
        C_NOP,
        C_ALU,
        C_JR,
        C_LW,
        C_SW,
        C_BEQ,
        C_J,
        C_JAL
    } iclass_t;

    typedef struct packed {
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       alusrc;
        logic [2:0] aluop;
        logic [1:0] sign;
    } mux_sel_t;

endpackage

// File: rtl/mips_mc_decode.sv
// rtl/mips_mc_decode.sv - opcode/funct to mux-select and class decoder
// Purpose: purely combinational map from the IR opcode and funct fields
//          to the datapath mux selects and an instruction class code.
//          Unsupported encodings decode as C_NOP with all selects 0.
// Ports:
//   i_option   in  6  opcode field
//   i_function in  6  funct field
//   o_sel      out    packed mux selects (regdst, memtoreg, alusrc, aluop, sign)
//   o_cls      out    instruction class
module mips_mc_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_option,
    input  logic [5:0] i_function,
    output mux_sel_t   o_sel,
    output iclass_t    o_cls
);

    always_comb begin
        o_sel = '0;
        o_cls = C_NOP;
        case (i_option)
            OP_RTYPE: begin
                case (i_function)
                    FN_ADDU: begin
                        o_cls        = C_ALU;
                        o_sel.regdst = REGDST_RD;
                        o_sel.aluop  = ALUOP_ADD;
                    end
                    FN_SUBU: begin
                        o_cls        = C_ALU;
                        o_sel.regdst = REGDST_RD;
                        o_sel.aluop  = ALUOP_SUB;
                    end
                    FN_JR: begin
                        o_cls = C_JR;
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                o_cls        = C_ALU;
                o_sel.alusrc = 1'b1;
                o_sel.aluop  = ALUOP_OR;
                o_sel.sign   = SIGN_ZERO;
            end
            OP_LUI: begin
                o_cls        = C_ALU;
                o_sel.alusrc = 1'b1;
                o_sel.aluop  = ALUOP_LUI;
                o_sel.sign   = SIGN_UPPER;
            end
            OP_LW: begin
                o_cls          = C_LW;
                o_sel.memtoreg = M2R_MEM;
                o_sel.alusrc   = 1'b1;
                o_sel.aluop    = ALUOP_ADD;
                o_sel.sign     = SIGN_SEXT;
            end
            OP_SW: begin
                o_cls        = C_SW;
                o_sel.alusrc = 1'b1;
                o_sel.aluop  = ALUOP_ADD;
                o_sel.sign   = SIGN_SEXT;
            end
            OP_BEQ: begin
                // Equality is judged by a subtract; the offset is signed.
                o_cls       = C_BEQ;
                o_sel.aluop = ALUOP_SUB;
                o_sel.sign  = SIGN_SEXT;
            end
            OP_J: begin
                o_cls = C_J;
            end
            OP_JAL: begin
                o_cls          = C_JAL;
                o_sel.regdst   = REGDST_RA;
                o_sel.memtoreg = M2R_PC4;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multi-cycle MIPS control FSM
// Purpose: sequences each instruction through FETCH/FWAIT/DECODE/EXE/
//          MEM/MWAIT/WB/JUMP, stalls on the memory ready handshake,
//          traps memory timeouts into a terminal ERR state and counts
//          retired instructions (saturating).
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   Option, Function    IR opcode / funct fields
//   Zero                ALU equality flag (beq)
//   mem_ready           memory completes the current request
//   mem_req, MemWrite   memory request / store qualifier
//   PCWr, IRWr          PC and IR write enables
//   PCSrc               next-PC select
//   Regdst, MemtoReg,
//   ALUSrc, ALUOp, Sign datapath mux selects
//   Regwrite            GPR write enable
//   bus_err             sticky memory-timeout flag
//   instr_cnt           retired-instruction counter
module mips_mc_controller
    import mips_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Option,
    input  logic [5:0]       Function,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             PCWr,
    output logic             IRWr,
    output logic [1:0]       PCSrc,
    output logic [1:0]       Regdst,
    output logic [1:0]       MemtoReg,
    output logic             ALUSrc,
    output logic [2:0]       ALUOp,
    output logic [1:0]       Sign,
    output logic             Regwrite,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_cnt
);

    // Count value seen on the WAIT_LIMIT-th wait cycle (counter starts at 0).
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_wait_cnt;
    logic             r_bus_err;
    logic [CNT_W-1:0] r_instr_cnt;

    mux_sel_t         w_sel;
    iclass_t          w_cls;
    logic             w_retire;
    logic             w_timeout;
    logic             w_sel_valid;
    logic             w_in_wait;

    mips_mc_decode u_decode (
        .i_option   (Option),
        .i_function (Function),
        .o_sel      (w_sel),
        .o_cls      (w_cls)
    );

    assign w_in_wait = (r_state == S_FWAIT) || (r_state == S_MWAIT);
    assign w_timeout = w_in_wait && !mem_ready && (r_wait_cnt == WAIT_LAST);

    // Next state and state-qualified enables
    always_comb begin
        w_next   = r_state;
        mem_req  = 1'b0;
        MemWrite = 1'b0;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        PCSrc    = PCSRC_PC4;
        Regwrite = 1'b0;
        w_retire = 1'b0;

        case (r_state)
            S_FETCH: begin
                // mem_ready is ignored here: completion needs a wait cycle.
                mem_req = 1'b1;
                w_next  = S_FWAIT;
            end
            S_FWAIT: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWr   = 1'b1;
                    PCWr   = 1'b1;
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_DECODE: begin
                if (w_cls == C_J || w_cls == C_JAL || w_cls == C_JR) begin
                    w_next = S_JUMP;
                end else begin
                    w_next = S_EXE;
                end
            end
            S_EXE: begin
                case (w_cls)
                    C_BEQ: begin
                        if (Zero) begin
                            PCWr  = 1'b1;
                            PCSrc = PCSRC_BR;
                        end
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                    C_NOP: begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                    C_LW, C_SW: w_next = S_MEM;
                    default:    w_next = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                MemWrite = (w_cls == C_SW);
                w_next   = S_MWAIT;
            end
            S_MWAIT: begin
                mem_req  = 1'b1;
                MemWrite = (w_cls == C_SW);
                if (mem_ready) begin
                    if (w_cls == C_SW) begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_WB: begin
                Regwrite = 1'b1;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_JUMP: begin
                PCWr     = 1'b1;
                PCSrc    = (w_cls == C_JR) ? PCSRC_REG : PCSRC_JMP;
                Regwrite = (w_cls == C_JAL);
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_ERR: begin
                w_next = S_ERR;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // While reset is held, nothing reaches memory or the datapath even
        // though the registered state may not have returned to FETCH yet.
        if (reset) begin
            mem_req  = 1'b0;
            MemWrite = 1'b0;
            PCWr     = 1'b0;
            IRWr     = 1'b0;
            PCSrc    = PCSRC_PC4;
            Regwrite = 1'b0;
            w_retire = 1'b0;
        end
    end

    // Mux selects: valid from DECODE through the instruction's last state,
    // zero while the IR is still being fetched, in ERR and under reset.
    always_comb begin
        w_sel_valid = 1'b0;
        case (r_state)
            S_DECODE, S_EXE, S_MEM, S_MWAIT, S_WB, S_JUMP: w_sel_valid = !reset;
            default: w_sel_valid = 1'b0;
        endcase
        Regdst   = w_sel_valid ? w_sel.regdst   : REGDST_RT;
        MemtoReg = w_sel_valid ? w_sel.memtoreg : M2R_ALU;
        ALUSrc   = w_sel_valid ? w_sel.alusrc   : 1'b0;
        ALUOp    = w_sel_valid ? w_sel.aluop    : ALUOP_ADD;
        Sign     = w_sel_valid ? w_sel.sign     : SIGN_ZERO;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_wait_cnt  <= '0;
            r_bus_err   <= 1'b0;
            r_instr_cnt <= '0;
        end else begin
            r_state <= w_next;

            // Cleared outside the wait states, so it is 0 on entry to either.
            if (w_in_wait) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= '0;
            end

            if (w_next == S_ERR) begin
                r_bus_err <= 1'b1;
            end

            if (w_retire && (r_instr_cnt != '1)) begin
                r_instr_cnt <= r_instr_cnt + 1'b1;
            end
        end
    end

    assign bus_err   = r_bus_err;
    assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - self-checking bench for mips_mc_controller
module tb_mips_mc_controller;

    localparam int WL = 4;
    localparam int CW = 2;

    localparam int K_NOP = 0;
    localparam int K_ALU = 1;
    localparam int K_JR  = 2;
    localparam int K_LW  = 3;
    localparam int K_SW  = 4;
    localparam int K_BEQ = 5;
    localparam int K_J   = 6;
    localparam int K_JAL = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    Option;
    logic [5:0]    Function;
    logic          Zero;
    logic          mem_ready;
    logic          mem_req;
    logic          MemWrite;
    logic          PCWr;
    logic          IRWr;
    logic [1:0]    PCSrc;
    logic [1:0]    Regdst;
    logic [1:0]    MemtoReg;
    logic          ALUSrc;
    logic [2:0]    ALUOp;
    logic [1:0]    Sign;
    logic          Regwrite;
    logic          bus_err;
    logic [CW-1:0] instr_cnt;

    int            checks   = 0;
    int            failures = 0;
    logic [CW-1:0] exp_cnt;
    logic [17:0]   w_obs;

    always #5 clk = ~clk;

    mips_mc_controller #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .Option    (Option),
        .Function  (Function),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .MemWrite  (MemWrite),
        .PCWr      (PCWr),
        .IRWr      (IRWr),
        .PCSrc     (PCSrc),
        .Regdst    (Regdst),
        .MemtoReg  (MemtoReg),
        .ALUSrc    (ALUSrc),
        .ALUOp     (ALUOp),
        .Sign      (Sign),
        .Regwrite  (Regwrite),
        .bus_err   (bus_err),
        .instr_cnt (instr_cnt)
    );

    assign w_obs = {mem_req, MemWrite, PCWr, IRWr, PCSrc, Regdst, MemtoReg,
                    ALUSrc, ALUOp, Sign, Regwrite, bus_err};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Instruction meaning, straight from the instruction table
    function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   return (fn == 6'h21 || fn == 6'h23) ? K_ALU : (fn == 6'h08) ? K_JR : K_NOP;
            6'h0D, 6'h0F: return K_ALU;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h02:   return K_J;
            6'h03:   return K_JAL;
            default: return K_NOP;
        endcase
    endfunction

    // {Regdst, MemtoReg, ALUSrc, ALUOp, Sign} each instruction needs
    function automatic logic [9:0] ref_sel(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   return (fn == 6'h21) ? {2'd1, 2'd0, 1'b0, 3'd0, 2'd0} :
                            (fn == 6'h23) ? {2'd1, 2'd0, 1'b0, 3'd1, 2'd0} : 10'd0;
            6'h0D:   return {2'd0, 2'd0, 1'b1, 3'd2, 2'd0};
            6'h0F:   return {2'd0, 2'd0, 1'b1, 3'd3, 2'd2};
            6'h23:   return {2'd0, 2'd1, 1'b1, 3'd0, 2'd1};
            6'h2B:   return {2'd0, 2'd0, 1'b1, 3'd0, 2'd1};
            6'h04:   return {2'd0, 2'd0, 1'b0, 3'd1, 2'd1};
            6'h03:   return {2'd2, 2'd2, 1'b0, 3'd0, 2'd0};
            default: return 10'd0;
        endcase
    endfunction

    function automatic logic [17:0] ev(input logic req, input logic mw, input logic pcw,
                                       input logic irw, input logic [1:0] pcs,
                                       input logic [9:0] sel, input logic rw, input logic be);
        return {req, mw, pcw, irw, pcs, sel, rw, be};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock: drive mem_ready, sample outputs on the falling edge.
    task automatic cyc(input string tag, input logic [17:0] exp, input logic rdy, input logic last);
        mem_ready = rdy;
        @(negedge clk);
        check(tag, 32'(w_obs), 32'(exp));
        check({tag, "_cnt"}, 32'(instr_cnt), 32'(exp_cnt));
        @(posedge clk);
        #1;
        if (last && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    endtask

    // to: 0 = no timeout, 1 = FWAIT timeout, 2 = MWAIT timeout
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw, input int to);
        int         k;
        logic [9:0] s;
        logic       isw;
        logic       tk;
        k   = kind(op, fn);
        s   = ref_sel(op, fn);
        isw = (k == K_SW);
        tk  = (k == K_BEQ) && z;
        Option   = op;
        Function = fn;
        Zero     = z;
        cyc("fetch", ev(1, 0, 0, 0, 2'd0, 10'd0, 0, 0), rbit(), 0);
        if (to == 1) begin
            for (int i = 0; i < WL; i++) cyc("fwait_to", ev(1, 0, 0, 0, 2'd0, 10'd0, 0, 0), 0, 0);
            return;
        end
        for (int i = 1; i <= fw; i++)
            cyc("fwait", ev(1, 0, i == fw, i == fw, 2'd0, 10'd0, 0, 0), i == fw, 0);
        cyc("decode", ev(0, 0, 0, 0, 2'd0, s, 0, 0), rbit(), 0);
        if (k == K_J || k == K_JAL || k == K_JR) begin
            cyc("jump", ev(0, 0, 1, 0, (k == K_JR) ? 2'd3 : 2'd2, s, k == K_JAL, 0), rbit(), 1);
            return;
        end
        if (k == K_BEQ || k == K_NOP) begin
            cyc("exe_end", ev(0, 0, tk, 0, tk ? 2'd1 : 2'd0, s, 0, 0), rbit(), 1);
            return;
        end
        cyc("exe", ev(0, 0, 0, 0, 2'd0, s, 0, 0), rbit(), 0);
        if (k == K_LW || k == K_SW) begin
            cyc("mem", ev(1, isw, 0, 0, 2'd0, s, 0, 0), rbit(), 0);
            if (to == 2) begin
                for (int i = 0; i < WL; i++) cyc("mwait_to", ev(1, isw, 0, 0, 2'd0, s, 0, 0), 0, 0);
                return;
            end
            for (int i = 1; i <= mw; i++)
                cyc("mwait", ev(1, isw, 0, 0, 2'd0, s, 0, 0), i == mw, isw && (i == mw));
            if (isw) return;
        end
        cyc("wb", ev(0, 0, 0, 0, 2'd0, s, 1, 0), rbit(), 1);
    endtask

    // ERR: nothing enabled, bus_err sticky, whatever the inputs do
    task automatic err_phase(input int n);
        for (int i = 0; i < n; i++) begin
            Option = 6'($urandom);
            Zero   = rbit();
            cyc("err", ev(0, 0, 0, 0, 2'd0, 10'd0, 0, 1), rbit(), 0);
        end
    endtask

    task automatic do_reset(input logic rdy);
        reset     = 1'b1;
        mem_ready = rdy;
        @(negedge clk);
        check("rst_gate", 32'(w_obs & 18'h3FFFE), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out", 32'(w_obs), 32'd0);
        check("rst_cnt", 32'(instr_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_cnt = '0;
    endtask

    initial begin
        logic [5:0] ops [9];
        logic [5:0] fns [4];
        logic [5:0] op;
        logic [5:0] fn;
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h3F};
        fns = '{6'h21, 6'h23, 6'h08, 6'h00};
        Option    = '0;
        Function  = '0;
        Zero      = 1'b0;
        mem_ready = 1'b0;
        exp_cnt   = '0;
        do_reset(1'b0);

        // Directed sequence from the test plan
        run_instr(6'h00, 6'h21, 0, 1, 1, 0);   // addu, 5 cycles
        run_instr(6'h23, 6'h00, 0, 1, 3, 0);   // lw, 9 cycles
        run_instr(6'h04, 6'h00, 1, 1, 1, 0);   // beq taken
        run_instr(6'h04, 6'h00, 0, 1, 1, 0);   // beq not taken (count saturates)
        run_instr(6'h03, 6'h00, 0, 1, 1, 0);   // jal
        run_instr(6'h3F, 6'h15, 1, 1, 1, 0);   // undefined -> nop
        run_instr(6'h0D, 6'h00, 0, WL, 1, 0);  // ready on the last allowed wait cycle
        run_instr(6'h2B, 6'h00, 0, 1, WL, 0);
        run_instr(6'h00, 6'h08, 0, 2, 1, 0);   // jr

        // Fetch timeout, sticky error, reset recovery
        run_instr(6'h00, 6'h21, 0, 1, 1, 1);
        err_phase(5);
        do_reset(1'b1);
        run_instr(6'h0F, 6'h00, 0, 1, 1, 0);

        // Memory-wait timeout on a load
        run_instr(6'h23, 6'h00, 0, 1, 1, 2);
        err_phase(3);
        do_reset(1'b0);

        // Reset wins over a timeout and over a completion in the same cycle
        for (int r = 0; r < 2; r++) begin
            Option   = 6'h23;
            Function = 6'h00;
            cyc("pre_fetch", ev(1, 0, 0, 0, 2'd0, 10'd0, 0, 0), 0, 0);
            for (int i = 0; i < WL - 1; i++)
                cyc("pre_fwait", ev(1, 0, 0, 0, 2'd0, 10'd0, 0, 0), 0, 0);
            do_reset(1'(r));
            run_instr(6'h00, 6'h23, 0, 1, 1, 0);
        end

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            op = ops[$urandom_range(0, 8)];
            fn = (op == 6'h00) ? fns[$urandom_range(0, 3)] : 6'($urandom);
            if (op == 6'h3F) op = 6'($urandom);
            run_instr(op, fn, rbit(), $urandom_range(1, WL), $urandom_range(1, WL), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
